// File: rtl/led_sequencer.sv
// Multi-channel LED sequencer: each channel runs fill/drain or chase/bounce,
// one channel at a time is shown on the LEDs and driven by the buttons.
module led_sequencer #(
   parameter int                    N_LEDS         = 5,
   parameter int                    N_CHANNELS     = 2,
   parameter int                    TICK           = 50_000_000,
   parameter logic [N_CHANNELS-1:0] CH_MODE        = '0,
   parameter bit                    PAUSE_INACTIVE = 1'b1
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic                                                 en,
   input  logic                                                 btn_sel,
   input  logic                                                 btn_go,
   output logic [N_LEDS-1:0]                                    out,
   output logic [((N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1)-1:0] active_ch
);

   localparam int AW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam int PW = $clog2(N_LEDS);
   localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;

   localparam logic [AW-1:0] LAST_CH   = AW'(N_CHANNELS - 1);
   localparam logic [PW-1:0] POS_LAST  = PW'(N_LEDS - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_FULL  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_CHASE = 3'd4;

   logic                               btn_sel_q, btn_go_q;
   logic                               arm_q;
   logic                               sel_edge, go_edge;
   logic [AW-1:0]                      active_q, active_d;
   logic [N_LEDS-1:0]                  out_q, out_d;
   logic [N_CHANNELS-1:0][2:0]         state_q, state_d;
   logic [N_CHANNELS-1:0][N_LEDS-1:0]  pat_q, pat_d;
   logic [N_CHANNELS-1:0][PW-1:0]      pos_q, pos_d;
   logic [N_CHANNELS-1:0]              dir_q, dir_d;   // 0 = up, 1 = down
   logic [N_CHANNELS-1:0][TW-1:0]      tmr_q, tmr_d;
   logic [PW-1:0]                      npos;

   always_comb begin
      // arm_q masks the first cycle after reset so a button held through reset is not an edge
      sel_edge = arm_q & btn_sel & ~btn_sel_q;
      go_edge  = arm_q & btn_go & ~btn_go_q & ~sel_edge;
      active_d = active_q;
      state_d  = state_q;
      pat_d    = pat_q;
      pos_d    = pos_q;
      dir_d    = dir_q;
      tmr_d    = tmr_q;
      npos     = '0;
      out_d    = '0;

      if (sel_edge)
         active_d = (active_q == LAST_CH) ? '0 : active_q + AW'(1);

      for (int c = 0; c < N_CHANNELS; c++) begin
         if (!PAUSE_INACTIVE || AW'(c) == active_q) begin
            case (state_q[c])
               S_IDLE: begin
                  tmr_d[c] = '0;
                  if (go_edge && AW'(c) == active_q) begin
                     state_d[c] = CH_MODE[c] ? S_CHASE : S_FILL;
                     pat_d[c]   = CH_MODE[c] ? N_LEDS'(1) : '0;
                     pos_d[c]   = '0;
                     dir_d[c]   = 1'b0;
                  end
               end
               S_FULL: begin
                  tmr_d[c] = '0;
                  if (go_edge && AW'(c) == active_q) begin
                     state_d[c] = S_DRAIN;
                     pos_d[c]   = POS_LAST;
                  end
               end
               S_FILL: begin
                  if (tmr_q[c] == TICK_LAST) begin
                     tmr_d[c]             = '0;
                     pat_d[c][pos_q[c]]   = 1'b1;
                     if (pos_q[c] == POS_LAST)
                        state_d[c] = S_FULL;
                     else
                        pos_d[c] = pos_q[c] + PW'(1);
                  end else begin
                     tmr_d[c] = tmr_q[c] + TW'(1);
                  end
               end
               S_DRAIN: begin
                  if (tmr_q[c] == TICK_LAST) begin
                     tmr_d[c]           = '0;
                     pat_d[c][pos_q[c]] = 1'b0;
                     if (pos_q[c] == '0)
                        state_d[c] = S_IDLE;
                     else
                        pos_d[c] = pos_q[c] - PW'(1);
                  end else begin
                     tmr_d[c] = tmr_q[c] + TW'(1);
                  end
               end
               S_CHASE: begin
                  if (go_edge && AW'(c) == active_q) begin
                     state_d[c] = S_IDLE;
                     pat_d[c]   = '0;
                     pos_d[c]   = '0;
                     dir_d[c]   = 1'b0;
                     tmr_d[c]   = '0;
                  end else if (tmr_q[c] == TICK_LAST) begin
                     tmr_d[c] = '0;
                     npos     = dir_q[c] ? pos_q[c] - PW'(1) : pos_q[c] + PW'(1);
                     pos_d[c] = npos;
                     pat_d[c] = N_LEDS'(1) << npos;
                     if (npos == POS_LAST)
                        dir_d[c] = 1'b1;
                     else if (npos == '0)
                        dir_d[c] = 1'b0;
                  end else begin
                     tmr_d[c] = tmr_q[c] + TW'(1);
                  end
               end
               default: begin
                  state_d[c] = S_IDLE;
                  pat_d[c]   = '0;
                  pos_d[c]   = '0;
                  dir_d[c]   = 1'b0;
                  tmr_d[c]   = '0;
               end
            endcase
         end
      end

      if (!en) begin
         active_d = '0;
         state_d  = '0;
         pat_d    = '0;
         pos_d    = '0;
         dir_d    = '0;
         tmr_d    = '0;
      end

      // Output mirrors the next pattern of the next displayed channel, so it lands with the state
      out_d = pat_d[active_d];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         btn_sel_q <= 1'b0;
         btn_go_q  <= 1'b0;
         arm_q     <= 1'b0;
         active_q  <= '0;
         out_q     <= '0;
         state_q   <= '0;
         pat_q     <= '0;
         pos_q     <= '0;
         dir_q     <= '0;
         tmr_q     <= '0;
      end else begin
         btn_sel_q <= btn_sel;
         btn_go_q  <= btn_go;
         arm_q     <= 1'b1;
         active_q  <= active_d;
         out_q     <= out_d;
         state_q   <= state_d;
         pat_q     <= pat_d;
         pos_q     <= pos_d;
         dir_q     <= dir_d;
         tmr_q     <= tmr_d;
      end
   end

   assign out       = out_q;
   assign active_ch = active_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: 5 LEDs, 2 channels (ch0 fill/drain, ch1 chase), TICK=4, frozen inactive channels.
module tb_led_sequencer;

   logic       clk;
   logic       rst;
   logic       en;
   logic       btn_sel;
   logic       btn_go;
   logic [4:0] out;
   logic       active_ch;

   led_sequencer #(
      .N_LEDS        (5),
      .N_CHANNELS    (2),
      .TICK          (4),
      .CH_MODE       (2'b10),
      .PAUSE_INACTIVE(1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .btn_sel  (btn_sel),
      .btn_go   (btn_go),
      .out      (out),
      .active_ch(active_ch)
   );

   typedef struct {
      logic       r, e, s, g;
      int         n;
      logic [4:0] eo;
      logic       ea;
   } vec_t;

   typedef struct {
      logic [4:0] o;
      logic       a;
      int         id;
   } exp_t;

   exp_t sbq[$];
   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic vec_t v(input logic r, e, s, g, input int n,
                              input logic [4:0] eo, input logic ea);
      vec_t t;
      t.r = r; t.e = e; t.s = s; t.g = g; t.n = n; t.eo = eo; t.ea = ea;
      return t;
   endfunction

   // Hold the inputs for t.n clocks; the expectation is queued when driven and
   // compared #1 after the last of those clock edges.
   task automatic apply(input vec_t t);
      exp_t x;
      rst     = t.r;
      en      = t.e;
      btn_sel = t.s;
      btn_go  = t.g;
      x.o  = t.eo;
      x.a  = t.ea;
      x.id = step_id;
      sbq.push_back(x);
      repeat (t.n) @(posedge clk);
      #1;
      x = sbq.pop_front();
      checks++;
      if (out !== x.o || active_ch !== x.a) begin
         errors++;
         $display("FAIL step%0d: out=%b active_ch=%0d, expected out=%b active_ch=%0d",
                  x.id, out, active_ch, x.o, x.a);
      end
      step_id++;
   endtask

   task automatic run(input logic r, e, s, g, input int n,
                      input logic [4:0] eo, input logic ea);
      apply(v(r, e, s, g, n, eo, ea));
   endtask

   initial begin
      rst = 1'b0; en = 1'b1; btn_sel = 1'b0; btn_go = 1'b0;

      // reset, fill to FULL, drain to IDLE on ch0
      tbl.push_back(v(0, 1, 0, 0, 2, 5'b00000, 0));
      tbl.push_back(v(1, 1, 0, 0, 2, 5'b00000, 0));
      tbl.push_back(v(1, 1, 0, 1, 1, 5'b00000, 0));
      tbl.push_back(v(1, 1, 0, 0, 4, 5'b00001, 0));
      tbl.push_back(v(1, 1, 0, 0, 4, 5'b00011, 0));
      tbl.push_back(v(1, 1, 0, 0, 4, 5'b00111, 0));
      tbl.push_back(v(1, 1, 0, 0, 4, 5'b01111, 0));
      tbl.push_back(v(1, 1, 0, 0, 4, 5'b11111, 0));
      tbl.push_back(v(1, 1, 0, 0, 8, 5'b11111, 0));
      tbl.push_back(v(1, 1, 0, 1, 1, 5'b11111, 0));
      tbl.push_back(v(1, 1, 0, 0, 4, 5'b01111, 0));
      tbl.push_back(v(1, 1, 0, 0, 4, 5'b00111, 0));
      tbl.push_back(v(1, 1, 0, 0, 4, 5'b00011, 0));
      tbl.push_back(v(1, 1, 0, 0, 4, 5'b00001, 0));
      tbl.push_back(v(1, 1, 0, 0, 4, 5'b00000, 0));
      tbl.push_back(v(1, 1, 0, 0, 8, 5'b00000, 0));
      // go during FILL is ignored and does not disturb the timer
      tbl.push_back(v(1, 1, 0, 1, 1, 5'b00000, 0));
      tbl.push_back(v(1, 1, 0, 0, 4, 5'b00001, 0));
      tbl.push_back(v(1, 1, 0, 1, 1, 5'b00001, 0));
      tbl.push_back(v(1, 1, 0, 0, 3, 5'b00011, 0));
      tbl.push_back(v(1, 1, 0, 0, 4, 5'b00111, 0));
      tbl.push_back(v(1, 1, 0, 0, 2, 5'b00111, 0));

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i]);

      // freeze: ch0 parked with timer 3, resumes stepping on the first cycle back
      run(1, 1, 1, 0, 1,  5'b00000, 1);
      run(1, 1, 0, 0, 40, 5'b00000, 1);
      run(1, 1, 1, 0, 1,  5'b00111, 0);
      run(1, 1, 0, 0, 1,  5'b01111, 0);
      run(1, 1, 0, 0, 4,  5'b11111, 0);

      // chase/bounce on ch1, then stop mid-run
      run(1, 1, 1, 0, 1, 5'b00000, 1);
      run(1, 1, 0, 1, 1, 5'b00001, 1);
      run(1, 1, 0, 0, 4, 5'b00010, 1);
      run(1, 1, 0, 0, 4, 5'b00100, 1);
      run(1, 1, 0, 0, 4, 5'b01000, 1);
      run(1, 1, 0, 0, 4, 5'b10000, 1);
      run(1, 1, 0, 0, 4, 5'b01000, 1);
      run(1, 1, 0, 0, 4, 5'b00100, 1);
      run(1, 1, 0, 0, 4, 5'b00010, 1);
      run(1, 1, 0, 0, 4, 5'b00001, 1);
      run(1, 1, 0, 0, 4, 5'b00010, 1);
      run(1, 1, 0, 0, 2, 5'b00010, 1);
      run(1, 1, 0, 1, 1, 5'b00000, 1);
      run(1, 1, 0, 0, 8, 5'b00000, 1);

      // simultaneous sel+go: selection moves, go is dropped on both channels
      run(1, 1, 0, 1, 1, 5'b00001, 1);
      run(1, 1, 0, 0, 2, 5'b00001, 1);
      run(1, 1, 1, 1, 1, 5'b11111, 0);
      run(1, 1, 0, 0, 4, 5'b11111, 0);
      run(1, 1, 1, 0, 1, 5'b00001, 1);
      run(1, 1, 0, 0, 1, 5'b00010, 1);

      // enable low aborts everything and swallows button edges
      run(1, 1, 1, 0, 1, 5'b11111, 0);
      run(1, 1, 0, 1, 1, 5'b11111, 0);
      run(1, 1, 0, 0, 8, 5'b00111, 0);
      run(1, 0, 0, 0, 1, 5'b00000, 0);
      run(1, 1, 0, 0, 1, 5'b00000, 0);
      run(1, 1, 0, 1, 1, 5'b00000, 0);
      run(1, 1, 0, 0, 4, 5'b00001, 0);
      run(1, 1, 0, 0, 8, 5'b00111, 0);
      run(1, 0, 0, 1, 1, 5'b00000, 0);
      run(1, 1, 0, 0, 4, 5'b00000, 0);
      run(1, 1, 0, 1, 1, 5'b00000, 0);
      run(1, 1, 0, 0, 4, 5'b00001, 0);
      run(1, 1, 1, 0, 1, 5'b00000, 1);

      // reset mid-chase with go held high: no start on release
      run(1, 1, 0, 1, 1, 5'b00001, 1);
      run(1, 1, 0, 0, 4, 5'b00010, 1);
      run(0, 1, 0, 1, 2, 5'b00000, 0);
      run(1, 1, 0, 1, 6, 5'b00000, 0);
      run(1, 1, 0, 0, 1, 5'b00000, 0);
      run(1, 1, 0, 1, 1, 5'b00000, 0);
      run(1, 1, 0, 0, 4, 5'b00001, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter N_LEDS, default 5: LEDs per channel, legal range 2..32.
REQ-002 SHALL have parameter N_CHANNELS, default 2: independent sequencer channels, legal range 1..8.
REQ-003 SHALL have parameter TICK, default 50_000_000: clock cycles per sequence step, minimum 1.
REQ-004 SHALL have parameter CH_MODE, default all zeros: N_CHANNELS-bit vector; bit c=0 makes channel c fill/drain, bit c=1 makes it chase/bounce.
REQ-005 SHALL have parameter PAUSE_INACTIVE, default 1: 1 freezes non-displayed channels, 0 lets all channels run.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 en  input  1  enable; low clears all channels.
REQ-009 btn_sel  input  1  level input; a rising edge advances the displayed channel.
REQ-010 btn_go  input  1  level input; a rising edge starts or stops the displayed channel.
REQ-011 out  output  N_LEDS  LED pattern of the displayed channel, registered.
REQ-012 active_ch  output  max(1,clog2(N_CHANNELS))  index of the displayed channel, registered.

Function
REQ-013 SHALL detect a button edge as (btn & ~btn_q), with btn_q registered every cycle regardless of en.
REQ-014 SHALL keep per-channel context: state, pattern[N_LEDS-1:0], pos, dir, timer.
REQ-015 SHALL define fill/drain states as IDLE, FILL, FULL, DRAIN, and chase states as IDLE, CHASE.
REQ-016 SHALL step a running channel only when its timer equals TICK-1; the step cycle SHALL return the timer to 0, otherwise the timer increments by 1.
REQ-017 SHALL clear the timer to 0 on every state change.
REQ-018 SHALL keep the timer at 0 in IDLE and FULL.
REQ-019 SHALL, on a go edge in IDLE for a fill/drain channel, enter FILL with pattern=0 and pos=0.
REQ-020 SHALL, on each FILL step, set pattern[pos] and increment pos; the step that sets bit N_LEDS-1 SHALL enter FULL.
REQ-021 SHALL, on a go edge in FULL, enter DRAIN with pos=N_LEDS-1.
REQ-022 SHALL, on each DRAIN step, clear pattern[pos] and decrement pos; the step that clears bit 0 SHALL enter IDLE with pos=0.
REQ-023 SHALL ignore go edges in FILL and DRAIN.
REQ-024 SHALL, on a go edge in IDLE for a chase channel, enter CHASE with pattern=1, pos=0, dir=up.
REQ-025 SHALL, on each CHASE step, move pos by one in direction dir and set pattern to one-hot(pos).
REQ-026 SHALL flip dir in CHASE on reaching N_LEDS-1 (to down) and on reaching 0 (to up), giving sequence 0,1,..,N-1,N-2,..,0,1,...
REQ-027 SHALL, on a go edge in CHASE, enter IDLE with pattern=0, pos=0, dir=up.
REQ-028 SHALL, on a sel edge, set active_ch to (active_ch+1) mod N_CHANNELS.
REQ-029 SHALL drive out from the newly selected channel's pattern one cycle after a sel edge.
REQ-030 SHALL give a sel edge priority over a go edge in the same cycle; that go edge is discarded.
REQ-031 SHALL apply go edges only to the displayed channel.
REQ-032 SHALL, when PAUSE_INACTIVE=1, hold all context (timer included) of non-displayed channels.
REQ-033 SHALL, when PAUSE_INACTIVE=0, advance all running channels every cycle.
REQ-034 SHALL register out, giving out = pattern of the displayed channel with one cycle latency; a go edge at cycle k is visible on out at k+1.
REQ-035 SHALL, when en=0 for any cycle, force all channels to IDLE with pattern/pos/timer=0 and dir=up, active_ch=0 and out=0, ignoring button edges.

Reset
REQ-036 SHALL, while rst=0 at a rising clk edge, set out=0, active_ch=0, btn_q=0, and every channel to IDLE with pattern=0, pos=0, dir=up, timer=0.
REQ-037 SHALL abort any sequence in progress on reset, with no residual pattern.

Verification
REQ-038 Fill/drain (N_LEDS=5, TICK=4, ch0 mode 0): go edge -> out 00001,00011,...,11111 at 4-cycle spacing then FULL; second go -> 01111...00000 then IDLE.
REQ-039 Chase (ch1 mode 1): sel, go -> out 00001,00010,00100,01000,10000,01000,00100,...; go mid-run -> out 00000 next cycle.
REQ-040 Freeze (PAUSE_INACTIVE=1): ch0 at 00111, sel to ch1, wait 40 cycles, sel back -> out 00111 and fill resumes with the timer value it held at the switch.
REQ-041 Simultaneous sel+go edges -> active_ch increments; neither channel changes state.
REQ-042 en low mid-FILL for 1 cycle -> out=0, active_ch=0; go afterwards restarts from 00001.
REQ-043 rst low mid-CHASE with btn_go held high -> out=0; releasing rst with btn_go still high causes no start (no edge).
